// File: rtl/camera_pkg.sv
// Shared definitions for the camera frame writer: record layout, status
// word bit positions and the writer FSM state encoding.
package camera_pkg;

    localparam int RECORD_WORDS = 7;

    localparam logic [2:0] W_SEQ     = 3'd0;
    localparam logic [2:0] W_COUNT   = 3'd1;
    localparam logic [2:0] W_SUM_X   = 3'd2;
    localparam logic [2:0] W_SUM_Y   = 3'd3;
    localparam logic [2:0] W_X_RANGE = 3'd4;
    localparam logic [2:0] W_Y_RANGE = 3'd5;
    localparam logic [2:0] W_STATUS  = 3'd6;

    localparam int STAT_VALID_BIT = 31;
    localparam int STAT_ERR_LSB   = 16;
    localparam int STAT_DROP_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Min sits in the upper half so the client can split the word with a shift.
    function automatic logic [31:0] pack_range(input logic [15:0] lo, input logic [15:0] hi);
        return {lo, hi};
    endfunction

endpackage

// File: rtl/camera_frame_writer_if.sv
// Pixel stream in, shared-memory host port and status out.
interface camera_frame_writer_if;

    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;
    logic [7:0]  thresh;
    logic [31:0] camera_addr;
    logic [31:0] camera_dout;
    logic        camera_mwe;
    logic        frame_done;
    logic        busy;

    modport master (
        output pix_valid, pix_data, pix_sof, pix_eol, pix_eof, thresh,
        input  camera_addr, camera_dout, camera_mwe, frame_done, busy
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof, thresh,
        output camera_addr, camera_dout, camera_mwe, frame_done, busy
    );

endinterface

// File: rtl/camera_frame_writer_stats.sv
// Per-frame statistics of bright pixels: position counters, hit count,
// coordinate sums and bounding box. 'start' restarts the frame on this pixel.
module frame_stats_accum #(
    parameter int X_W = 10,
    parameter int Y_W = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           apply,
    input  logic [7:0]     pix_data,
    input  logic           pix_eol,
    input  logic [7:0]     thresh,
    output logic [31:0]    count,
    output logic [31:0]    sum_x,
    output logic [31:0]    sum_y,
    output logic [X_W-1:0] min_x,
    output logic [X_W-1:0] max_x,
    output logic [Y_W-1:0] min_y,
    output logic [Y_W-1:0] max_y
);

    localparam logic [X_W-1:0] X_ONE = 1;
    localparam logic [Y_W-1:0] Y_ONE = 1;

    logic [7:0]     thresh_q;
    logic [7:0]     thr_eff;
    logic [X_W-1:0] x_q, x_eff, min_x_base, max_x_base;
    logic [Y_W-1:0] y_q, y_eff, min_y_base, max_y_base;
    logic [31:0]    count_base, sum_x_base, sum_y_base;
    logic           hit;

    // On the sof pixel everything starts from the frame-initial values, so the
    // sof pixel is judged against the freshly sampled threshold at (0,0).
    always_comb begin
        thr_eff    = start ? thresh : thresh_q;
        x_eff      = start ? '0 : x_q;
        y_eff      = start ? '0 : y_q;
        count_base = start ? '0 : count;
        sum_x_base = start ? '0 : sum_x;
        sum_y_base = start ? '0 : sum_y;
        min_x_base = start ? '1 : min_x;
        max_x_base = start ? '0 : max_x;
        min_y_base = start ? '1 : min_y;
        max_y_base = start ? '0 : max_y;
        hit        = apply && (pix_data >= thr_eff);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            thresh_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            count    <= '0;
            sum_x    <= '0;
            sum_y    <= '0;
            min_x    <= '0;
            max_x    <= '0;
            min_y    <= '0;
            max_y    <= '0;
        end else if (apply) begin
            thresh_q <= thr_eff;
            if (pix_eol) begin
                x_q <= '0;
                y_q <= y_eff + Y_ONE;
            end else begin
                x_q <= x_eff + X_ONE;
                y_q <= y_eff;
            end
            count <= count_base + {31'd0, hit};
            sum_x <= hit ? sum_x_base + 32'(x_eff) : sum_x_base;
            sum_y <= hit ? sum_y_base + 32'(y_eff) : sum_y_base;
            min_x <= (hit && (x_eff < min_x_base)) ? x_eff : min_x_base;
            max_x <= (hit && (x_eff > max_x_base)) ? x_eff : max_x_base;
            min_y <= (hit && (y_eff < min_y_base)) ? y_eff : min_y_base;
            max_y <= (hit && (y_eff > max_y_base)) ? y_eff : max_y_base;
        end
    end

endmodule

// File: rtl/camera_frame_writer.sv
// Frame writer top: tracks frames on the pixel stream and writes the 7-word
// statistics record into shared memory, status word last.
module camera_frame_writer
    import camera_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          X_W       = 10,
    parameter int          Y_W       = 10
) (
    input logic                 clk,
    input logic                 reset,
    camera_frame_writer_if.slave bus
);

    state_t         state;
    logic [2:0]     word_idx, next_idx;
    logic [31:0]    seq, seq_next;
    logic [7:0]     err_cnt;
    logic [15:0]    drop_cnt;
    logic           sof_seen, start, apply, frame_end;
    logic [31:0]    rec_word, status_word;
    logic [31:0]    addr_q, dout_q;
    logic           mwe_q, done_q, busy_q;

    logic [31:0]    count, sum_x, sum_y;
    logic [X_W-1:0] min_x, max_x;
    logic [Y_W-1:0] min_y, max_y;

    // A sof seen in WRITE never starts a frame; that frame is lost entirely.
    always_comb begin
        sof_seen  = bus.pix_valid & bus.pix_sof;
        start     = sof_seen & (state != WRITE);
        apply     = bus.pix_valid & ((state == ACCUM) | start);
        frame_end = bus.pix_valid & bus.pix_eof & ((state == ACCUM) | start);
    end

    frame_stats_accum #(.X_W(X_W), .Y_W(Y_W)) u_stats (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .apply    (apply),
        .pix_data (bus.pix_data),
        .pix_eol  (bus.pix_eol),
        .thresh   (bus.thresh),
        .count    (count),
        .sum_x    (sum_x),
        .sum_y    (sum_y),
        .min_x    (min_x),
        .max_x    (max_x),
        .min_y    (min_y),
        .max_y    (max_y)
    );

    always_comb begin
        next_idx    = word_idx + 3'd1;
        seq_next    = seq + 32'd1;
        status_word = '0;
        status_word[STAT_VALID_BIT]      = (count != 32'd0);
        status_word[STAT_ERR_LSB +: 8]   = err_cnt;
        status_word[STAT_DROP_LSB +: 16] = drop_cnt;
        case (next_idx)
            W_COUNT:   rec_word = count;
            W_SUM_X:   rec_word = sum_x;
            W_SUM_Y:   rec_word = sum_y;
            W_X_RANGE: rec_word = (count == 32'd0) ? '0 : pack_range(16'(min_x), 16'(max_x));
            W_Y_RANGE: rec_word = (count == 32'd0) ? '0 : pack_range(16'(min_y), 16'(max_y));
            W_STATUS:  rec_word = status_word;
            default:   rec_word = seq;
        endcase
    end

    // word_idx names the record word currently on the host port; word 0 goes
    // out on the eof edge so the whole record occupies the following 7 cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            word_idx <= W_SEQ;
            seq      <= '0;
            err_cnt  <= '0;
            drop_cnt <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
            mwe_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            mwe_q  <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ACCUM;
                        busy_q <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (sof_seen && (err_cnt != 8'hFF))
                        err_cnt <= err_cnt + 8'd1;
                end
                WRITE: begin
                    if (sof_seen && (drop_cnt != 16'hFFFF))
                        drop_cnt <= drop_cnt + 16'd1;
                    if (word_idx == W_STATUS) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        word_idx <= next_idx;
                        mwe_q    <= 1'b1;
                        addr_q   <= BASE_ADDR + {27'd0, next_idx, 2'b00};
                        dout_q   <= rec_word;
                        done_q   <= (next_idx == W_STATUS);
                    end
                end
                default: state <= IDLE;
            endcase
            if (frame_end) begin
                state    <= WRITE;
                busy_q   <= 1'b1;
                word_idx <= W_SEQ;
                mwe_q    <= 1'b1;
                addr_q   <= BASE_ADDR;
                dout_q   <= seq_next;
                seq      <= seq_next;
            end
        end
    end

    assign bus.camera_addr = addr_q;
    assign bus.camera_dout = dout_q;
    assign bus.camera_mwe  = mwe_q;
    assign bus.frame_done  = done_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_camera_frame_writer.sv
// Randomized self-checking bench for camera_frame_writer against a per-frame
// reference model computed directly from the pixel image.
module tb_camera_frame_writer;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    camera_frame_writer_if bus();

    camera_frame_writer #(.BASE_ADDR(BASE), .X_W(10), .Y_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  pix [0:15][0:15];
    logic [31:0] exp_rec [0:6];
    logic [31:0] got_rec [0:6];
    int model_seq, model_err, model_drop;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic setPixel(input logic valid, input logic [7:0] data, input logic sof, input logic eol, input logic eof);
        bus.pix_valid = valid;
        bus.pix_data  = data;
        bus.pix_sof   = sof;
        bus.pix_eol   = eol;
        bus.pix_eof   = eof;
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic sof, input logic eol, input logic eof);
        @(negedge clk);
        setPixel(valid, data, sof, eol, eof);
    endtask

    task automatic fillRandom(input int w, input int h, input int thr);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                case ($urandom_range(0, 3))
                    0:       pix[y][x] = 8'(thr);
                    1:       pix[y][x] = 8'(thr - 1);
                    default: pix[y][x] = 8'($urandom);
                endcase
    endtask

    // Sends pix[][] raster-order; stop_after > 0 cuts the frame short with no eof.
    task automatic sendFrame(input int w, input int h, input int thr, input int stop_after, input bit gaps);
        int n;
        n = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (stop_after > 0 && n == stop_after) return;
                if (gaps && n > 0 && $urandom_range(0, 3) == 0)
                    applyStimulus(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                applyStimulus(1'b1, pix[y][x], (x == 0 && y == 0), (x == w - 1), (x == w - 1 && y == h - 1));
                bus.thresh = (n == 0) ? 8'(thr) : 8'($urandom);
                n++;
            end
        end
    endtask

    task automatic modelFrame(input int w, input int h, input int thr);
        int cnt, sx, sy, mnx, mxx, mny, mxy;
        cnt = 0; sx = 0; sy = 0;
        mnx = 65535; mxx = 0; mny = 65535; mxy = 0;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                if (int'(pix[y][x]) >= thr) begin
                    cnt++;
                    sx += x;
                    sy += y;
                    if (x < mnx) mnx = x;
                    if (x > mxx) mxx = x;
                    if (y < mny) mny = y;
                    if (y > mxy) mxy = y;
                end
        model_seq++;
        exp_rec[0] = 32'(model_seq);
        exp_rec[1] = 32'(cnt);
        exp_rec[2] = 32'(sx);
        exp_rec[3] = 32'(sy);
        exp_rec[4] = (cnt != 0) ? 32'(mnx * 65536 + mxx) : 32'd0;
        exp_rec[5] = (cnt != 0) ? 32'(mny * 65536 + mxy) : 32'd0;
        exp_rec[6] = 32'(((cnt != 0) ? 32'h8000_0000 : 32'd0) + model_err * 65536 + model_drop);
    endtask

    // Watches the host port after an eof; optionally injects a sof in the first
    // WRITE cycle or asserts reset while word reset_at is on the port.
    task automatic collectRecord(input bit inject_sof, input int reset_at, input bit skip_status);
        int n;
        bit stop;
        n = 0;
        stop = 1'b0;
        for (int k = 1; k <= 10 && !stop; k++) begin
            @(negedge clk);
            if (bus.camera_mwe) begin
                if (n == 0) checkOutput("latency", 32'(k), 32'd1);
                if (n < 7) begin
                    checkOutput($sformatf("addr%0d", n), bus.camera_addr, BASE + 32'(4 * n));
                    if (!(skip_status && n == 6))
                        checkOutput($sformatf("w%0d", n), bus.camera_dout, exp_rec[n]);
                    checkOutput($sformatf("done%0d", n), {31'd0, bus.frame_done}, {31'd0, n == 6});
                    checkOutput($sformatf("busy%0d", n), {31'd0, bus.busy}, 32'd1);
                    got_rec[n] = bus.camera_dout;
                end else begin
                    checkOutput("extra_write", {31'd0, bus.camera_mwe}, 32'd0);
                end
                if (n == reset_at) begin
                    reset = 1'b1;
                    @(negedge clk);
                    checkOutput("rst_mwe", {31'd0, bus.camera_mwe}, 32'd0);
                    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
                    reset = 1'b0;
                    stop = 1'b1;
                end
                n++;
            end else if (n > 0 && n < 7) begin
                checkOutput("gap_mwe", {31'd0, bus.camera_mwe}, 32'd1);
            end else if (n == 7) begin
                checkOutput("idle_done", {31'd0, bus.frame_done}, 32'd0);
                checkOutput("idle_busy", {31'd0, bus.busy}, 32'd0);
            end
            if (inject_sof && k == 1) setPixel(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
            else                      setPixel(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        end
        if (reset_at < 0) checkOutput("rec_len", 32'(n), 32'd7);
    endtask

    task automatic randomFrame(input bit gaps);
        int w, h, thr;
        w = $urandom_range(2, 12);
        h = $urandom_range(1, 8);
        thr = $urandom_range(0, 255);
        fillRandom(w, h, thr);
        sendFrame(w, h, thr, 0, gaps);
        modelFrame(w, h, thr);
        collectRecord(1'b0, -1, 1'b0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        setPixel(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        bus.thresh = 8'd0;
        model_seq = 0; model_err = 0; model_drop = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_addr", bus.camera_addr, 32'd0);
        checkOutput("rst_dout", bus.camera_dout, 32'd0);
        checkOutput("rst_mwe0", {31'd0, bus.camera_mwe}, 32'd0);
        checkOutput("rst_done0", {31'd0, bus.frame_done}, 32'd0);
        checkOutput("rst_busy0", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;

        // 4x2 frame with two bright pixels
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) pix[y][x] = 8'd0;
        pix[0][1] = 8'd200;
        pix[1][3] = 8'd200;
        sendFrame(4, 2, 100, 0, 1'b0);
        modelFrame(4, 2, 100);
        collectRecord(1'b0, -1, 1'b0);
        checkOutput("dir_w0", got_rec[0], 32'd1);
        checkOutput("dir_w1", got_rec[1], 32'd2);
        checkOutput("dir_w2", got_rec[2], 32'd4);
        checkOutput("dir_w3", got_rec[3], 32'd1);
        checkOutput("dir_w4", got_rec[4], 32'h0001_0003);
        checkOutput("dir_w5", got_rec[5], 32'h0000_0001);
        checkOutput("dir_w6", got_rec[6], 32'h8000_0000);

        // frame with no hits
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 5; x++) pix[y][x] = 8'($urandom_range(0, 254));
        sendFrame(5, 3, 255, 0, 1'b1);
        modelFrame(5, 3, 255);
        collectRecord(1'b0, -1, 1'b0);
        checkOutput("nohit_w0", got_rec[0], 32'd2);
        checkOutput("nohit_w4", got_rec[4], 32'd0);
        checkOutput("nohit_valid", {31'd0, got_rec[6][31]}, 32'd0);

        // pixel equal to the threshold is a hit
        pix[0][0] = 8'd49; pix[0][1] = 8'd50; pix[0][2] = 8'd51;
        sendFrame(3, 1, 50, 0, 1'b0);
        modelFrame(3, 1, 50);
        collectRecord(1'b0, -1, 1'b0);
        checkOutput("eq_count", got_rec[1], 32'd2);
        checkOutput("eq_sumx", got_rec[2], 32'd3);

        // sof in the first WRITE cycle: record completes, that frame is dropped
        fillRandom(6, 3, 120);
        sendFrame(6, 3, 120, 0, 1'b0);
        modelFrame(6, 3, 120);
        collectRecord(1'b1, -1, 1'b1);
        model_drop = (model_drop < 65535) ? model_drop + 1 : 65535;
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 8'hFF, 1'b0, (i == 3), (i == 3));
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("blind_mwe", {31'd0, bus.camera_mwe}, 32'd0);
        end
        randomFrame(1'b0);
        checkOutput("drop_status", {16'd0, got_rec[6][15:0]}, 32'd1);

        // restart without eof: only the second frame counts
        fillRandom(5, 4, 90);
        sendFrame(5, 4, 90, 7, 1'b1);
        fillRandom(5, 4, 140);
        sendFrame(5, 4, 140, 0, 1'b1);
        model_err = (model_err < 255) ? model_err + 1 : 255;
        modelFrame(5, 4, 140);
        collectRecord(1'b0, -1, 1'b0);
        checkOutput("err_status", {24'd0, got_rec[6][23:16]}, 32'd1);

        // reset while word 3 is on the host port
        fillRandom(4, 4, 80);
        sendFrame(4, 4, 80, 0, 1'b0);
        modelFrame(4, 4, 80);
        collectRecord(1'b0, 3, 1'b0);
        model_seq = 0; model_err = 0; model_drop = 0;
        randomFrame(1'b1);
        checkOutput("post_rst_w0", got_rec[0], 32'd1);

        for (int f = 0; f < 20; f++) randomFrame(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
